jtkicker_dwnld_remap: RTL and testbench

Parametrised ROM-download address remapper for the Kicker-family cores. It sits between the jtframe ioctl download port and the SDRAM/PROM write path. Each download byte is classified into one of `NREG` contiguous address regions, and the region's bit-permutation mode is applied to the address. The block emits a registered write stream plus PROM write enables, a per-download checksum and a completion pulse. It replaces hand-written per-game combinational `pre_addr` logic with a configurable, pipelined block.

---
 rtl/jtkicker_dwnld_pkg.sv | 16 +
 rtl/jtkicker_dwnld_swz.sv | 32 +++
 rtl/jtkicker_dwnld_remap.sv | 170 +++++++++++++++++
 tb/tb_jtkicker_dwnld_remap.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtkicker_dwnld_pkg.sv
// Shared constants for the Kicker ROM-download remapper: region modes,
// control FSM encoding and the default CHAR-mode XOR.
package jtkicker_dwnld_pkg;

  localparam logic [1:0] MODE_LINEAR = 2'd0;
  localparam logic [1:0] MODE_CHAR   = 2'd1;
  localparam logic [1:0] MODE_OBJ    = 2'd2;
  localparam logic [1:0] MODE_PROM   = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  localparam logic [2:0] CHR_XOR_DEF = 3'd1;

endpackage

// File: rtl/jtkicker_dwnld_swz.sv
// Stage-2 address permutation: purely combinational, one mode at a time.
module jtkicker_dwnld_swz
  import jtkicker_dwnld_pkg::*;
#(
  parameter int         AW      = 22,
  parameter logic [2:0] CHR_XOR = CHR_XOR_DEF
) (
  input  logic [1:0]    mode,
  input  logic [AW-1:0] addr_in,
  output logic [AW-1:0] addr_out
);

  // Reorder the low address bits according to the region mode
  always_comb begin
    addr_out = addr_in;
    case (mode)
      MODE_CHAR: begin
        addr_out[0]   = addr_in[3];
        addr_out[3:1] = addr_in[2:0] ^ CHR_XOR;
      end
      MODE_OBJ: begin
        addr_out[0]   = ~addr_in[3];
        addr_out[1]   = ~addr_in[4];
        addr_out[5:2] = {addr_in[5], addr_in[2:0]};
      end
      default: begin
        addr_out = addr_in;
      end
    endcase
  end

endmodule

// File: rtl/jtkicker_dwnld_remap.sv
// Two-stage ROM-download address remapper: region classification, per-region
// bit permutation, PROM write steering, download checksum and completion pulse.
module jtkicker_dwnld_remap
  import jtkicker_dwnld_pkg::*;
#(
  parameter int         NREG    = 4,
  parameter int         AW      = 22,
  parameter logic [2:0] CHR_XOR = CHR_XOR_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ioctl_rom,
  input  logic             ioctl_wr,
  input  logic [AW-1:0]    ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  input  logic [NREG*AW-1:0] reg_start,
  input  logic [NREG*2-1:0]  reg_mode,
  output logic [AW-1:0]    pre_addr,
  output logic [7:0]       pre_data,
  output logic             pre_wr,
  output logic             prom_we,
  output logic [AW-1:0]    prom_addr,
  output logic [15:0]      cksum,
  output logic             dwn_done
);

  localparam int IW = $clog2(NREG);

  logic            rom_last_r;
  logic            rom_rise_s;
  logic            accept_s;
  logic [1:0]      state_r;

  logic [IW-1:0]   idx_s;
  logic [1:0]      mode_s;

  logic            s1_valid_r;
  logic [AW-1:0]   s1_addr_r;
  logic [7:0]      s1_data_r;
  logic [IW-1:0]   s1_idx_r;
  logic [1:0]      s1_mode_r;

  logic [AW-1:0]   swz_addr_s;
  logic [AW-1:0]   base_s;

  assign rom_rise_s = ioctl_rom & ~rom_last_r;
  // The rising-edge cycle accepts a byte even though the FSM is still IDLE/DRAIN
  assign accept_s   = ioctl_wr & ((state_r == ST_ACTIVE) | rom_rise_s);

  // Region lookup: the highest region whose start is not above the address wins
  always_comb begin
    idx_s  = '0;
    mode_s = MODE_LINEAR;
    for (int i = 0; i < NREG; i++) begin
      if (ioctl_addr >= reg_start[i*AW +: AW]) begin
        idx_s  = IW'(i);
        mode_s = reg_mode[i*2 +: 2];
      end else begin
        idx_s  = idx_s;
        mode_s = mode_s;
      end
    end
  end

  // Start address of the region latched in stage 1, used for PROM offsets
  always_comb begin
    base_s = '0;
    for (int i = 0; i < NREG; i++) begin
      if (s1_idx_r == IW'(i)) begin
        base_s = reg_start[i*AW +: AW];
      end else begin
        base_s = base_s;
      end
    end
  end

  jtkicker_dwnld_swz #(
    .AW      (AW),
    .CHR_XOR (CHR_XOR)
  ) u_swz (
    .mode     (s1_mode_r),
    .addr_in  (s1_addr_r),
    .addr_out (swz_addr_s)
  );

  // Stage 1: capture accepted bytes with their region classification
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_last_r <= 1'b0;
      s1_valid_r <= 1'b0;
      s1_addr_r  <= '0;
      s1_data_r  <= 8'd0;
      s1_idx_r   <= '0;
      s1_mode_r  <= MODE_LINEAR;
    end else begin
      rom_last_r <= ioctl_rom;
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_addr_r <= ioctl_addr;
        s1_data_r <= ioctl_dout;
        s1_idx_r  <= idx_s;
        s1_mode_r <= mode_s;
      end
    end
  end

  // Stage 2: steer the byte to the SDRAM path or the PROM path; outputs hold between strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_wr    <= 1'b0;
      prom_we   <= 1'b0;
      pre_addr  <= '0;
      pre_data  <= 8'd0;
      prom_addr <= '0;
    end else begin
      pre_wr  <= s1_valid_r & (s1_mode_r != MODE_PROM);
      prom_we <= s1_valid_r & (s1_mode_r == MODE_PROM);
      if (s1_valid_r) begin
        pre_data <= s1_data_r;
        if (s1_mode_r == MODE_PROM) begin
          prom_addr <= s1_addr_r - base_s;
        end else begin
          pre_addr <= swz_addr_s;
        end
      end
    end
  end

  // Running byte sum, restarted by every new download
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cksum <= 16'd0;
    end else if (rom_rise_s) begin
      cksum <= accept_s ? {8'd0, ioctl_dout} : 16'd0;
    end else if (accept_s) begin
      cksum <= cksum + {8'd0, ioctl_dout};
    end
  end

  // Download control: the done pulse is issued once stage 1 holds nothing and
  // nothing new enters, so it lands the cycle after the last write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      dwn_done <= 1'b0;
    end else begin
      dwn_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rom_rise_s) state_r <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (!ioctl_rom) state_r <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (rom_rise_s) begin
            state_r <= ST_ACTIVE;
          end else if (!s1_valid_r && !accept_s) begin
            state_r  <= ST_IDLE;
            dwn_done <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtkicker_dwnld_remap.sv
// Randomised self-checking bench for jtkicker_dwnld_remap against a
// behavioural model of the region/mode rules.
module tb_jtkicker_dwnld_remap;

  localparam int NREG = 4;
  localparam int AW   = 22;
  localparam int CHRX = 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ioctl_rom;
  logic               ioctl_wr;
  logic [AW-1:0]      ioctl_addr;
  logic [7:0]         ioctl_dout;
  logic [NREG*AW-1:0] reg_start;
  logic [NREG*2-1:0]  reg_mode;
  logic [AW-1:0]      pre_addr;
  logic [7:0]         pre_data;
  logic               pre_wr;
  logic               prom_we;
  logic [AW-1:0]      prom_addr;
  logic [15:0]        cksum;
  logic               dwn_done;

  jtkicker_dwnld_remap #(.NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ioctl_rom(ioctl_rom), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .reg_start(reg_start),
    .reg_mode(reg_mode), .pre_addr(pre_addr), .pre_data(pre_data),
    .pre_wr(pre_wr), .prom_we(prom_we), .prom_addr(prom_addr),
    .cksum(cksum), .dwn_done(dwn_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int done_seen = 0;

  // model configuration
  logic [AW-1:0] st [NREG];
  logic [1:0]    md [NREG];

  // model state
  logic          m_rom_prev;
  logic          fall_pending;
  logic [15:0]   m_sum;
  logic          p_valid, p_prom;
  logic [AW-1:0] p_addr, p_off;
  logic [7:0]    p_data;
  logic [AW-1:0] m_paddr, m_poff;
  logic [7:0]    m_data;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_rom_prev = 1'b0; fall_pending = 1'b0; m_sum = 16'd0;
    p_valid = 1'b0; p_prom = 1'b0; p_addr = '0; p_off = '0; p_data = 8'd0;
    m_paddr = '0; m_poff = '0; m_data = 8'd0;
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < NREG; i++) begin
      reg_start[i*AW +: AW] = st[i];
      reg_mode[i*2 +: 2]    = md[i];
    end
  endtask

  // Behavioural mapping: find region, then rebuild the low bits arithmetically
  task automatic model_map(input logic [AW-1:0] a, output logic is_prom,
                           output logic [AW-1:0] ra, output logic [AW-1:0] off);
    int r, m, lo, nlo, b3, b4, b5;
    r = -1;
    for (int i = 0; i < NREG; i++) if (a >= st[i]) r = i;
    m = (r < 0) ? 0 : int'(md[r]);
    lo = int'(a[5:0]);
    b3 = (lo / 8) % 2; b4 = (lo / 16) % 2; b5 = lo / 32;
    is_prom = 1'b0; ra = a; off = '0;
    case (m)
      1: begin
        nlo = b5 * 32 + b4 * 16 + (((lo % 8) ^ CHRX) * 2) + b3;
        ra  = a - AW'(lo) + AW'(nlo);
      end
      2: begin
        nlo = b5 * 32 + (lo % 8) * 4 + (1 - b4) * 2 + (1 - b3);
        ra  = a - AW'(lo) + AW'(nlo);
      end
      3: begin
        is_prom = 1'b1;
        off = a - st[r];
      end
      default: ra = a;
    endcase
  endtask

  // One clock: drive inputs, advance model, check every output
  task automatic tick(input logic rom, input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
    logic rise, acc, is_prom, done_exp;
    logic [AW-1:0] ra, off;
    ioctl_rom = rom; ioctl_wr = wr; ioctl_addr = a; ioctl_dout = d;
    rise = rom && !m_rom_prev;
    acc  = wr && rom;
    model_map(a, is_prom, ra, off);
    done_exp = fall_pending && !rom;
    fall_pending = !rom && m_rom_prev;
    if (rise) m_sum = acc ? 16'(d) : 16'd0;
    else if (acc) m_sum = m_sum + 16'(d);
    m_rom_prev = rom;
    @(posedge clk); @(negedge clk);
    if (p_valid) begin
      m_data = p_data;
      if (p_prom) m_poff = p_off; else m_paddr = p_addr;
    end
    chk_eq("pre_wr",    32'(pre_wr),    32'(p_valid && !p_prom));
    chk_eq("prom_we",   32'(prom_we),   32'(p_valid && p_prom));
    chk_eq("pre_addr",  32'(pre_addr),  32'(m_paddr));
    chk_eq("pre_data",  32'(pre_data),  32'(m_data));
    chk_eq("prom_addr", 32'(prom_addr), 32'(m_poff));
    chk_eq("cksum",     32'(cksum),     32'(m_sum));
    chk_eq("dwn_done",  32'(dwn_done),  32'(done_exp));
    if (dwn_done) done_seen++;
    p_valid = acc; p_prom = is_prom; p_addr = ra; p_off = off; p_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, AW'($urandom), 8'($urandom));
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int k, r;
    k = $urandom_range(0, 3);
    r = $urandom_range(0, NREG - 1);
    case (k)
      0: return AW'($urandom);
      1: return st[r];
      2: return st[r] - AW'(1);
      default: return '1;
    endcase
  endfunction

  task automatic rand_cfg();
    logic [AW-1:0] t;
    for (int i = 0; i < NREG; i++) begin
      st[i] = AW'($urandom);
      md[i] = 2'($urandom);
    end
    for (int i = 0; i < NREG; i++)
      for (int j = 0; j < NREG - 1; j++)
        if (st[j] > st[j+1]) begin t = st[j]; st[j] = st[j+1]; st[j+1] = t; end
    if ($urandom_range(0, 1) == 0) st[0] = '0;
    if ($urandom_range(0, 2) == 0) st[2] = st[1];
    apply_cfg();
  endtask

  task automatic rand_download(input int nbytes);
    int sent;
    sent = 0;
    tick(1'b1, 1'b0, '0, 8'd0);
    while (sent < nbytes) begin
      if ($urandom_range(0, 2) != 0) begin
        tick(1'b1, 1'b1, pick_addr(), 8'($urandom));
        sent++;
      end else begin
        tick(1'b1, 1'b0, pick_addr(), 8'($urandom));
      end
    end
    idle(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ioctl_rom = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = 8'd0;
    st[0] = 22'h000000; st[1] = 22'h008000; st[2] = 22'h00C000; st[3] = 22'h010000;
    md[0] = 2'd0; md[1] = 2'd1; md[2] = 2'd2; md[3] = 2'd3;
    apply_cfg();
    model_reset();
    repeat (3) @(negedge clk);
    chk_eq("rst_pre_wr",   32'(pre_wr),   32'd0);
    chk_eq("rst_prom_we",  32'(prom_we),  32'd0);
    chk_eq("rst_pre_addr", 32'(pre_addr), 32'd0);
    chk_eq("rst_cksum",    32'(cksum),    32'd0);
    chk_eq("rst_done",     32'(dwn_done), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // directed addresses; the last strobe sits right before the falling edge
    tick(1'b1, 1'b0, '0, 8'd0);
    tick(1'b1, 1'b1, 22'h008005, 8'h11);
    tick(1'b1, 1'b1, 22'h00C018, 8'h22);
    tick(1'b1, 1'b1, 22'h00C000, 8'h33);
    tick(1'b1, 1'b1, 22'h010123, 8'h5A);
    tick(1'b1, 1'b1, 22'h007FFF, 8'h44);
    tick(1'b1, 1'b1, 22'h008000, 8'h55);
    tick(1'b1, 1'b1, 22'h3FFFFF, 8'h66);
    tick(1'b1, 1'b1, 22'h00FFFF, 8'h77);
    idle(5);

    // 300 x 0xFF, first byte on the rising-edge cycle
    done_seen = 0;
    for (int i = 0; i < 300; i++) tick(1'b1, 1'b1, AW'($urandom), 8'hFF);
    idle(5);
    chk_eq("cksum300",  32'(cksum),  32'h2AD4);
    chk_eq("done_once", 32'(done_seen), 32'd1);

    // second download restarts the checksum
    rand_download(10);

    // strobes while idle are ignored
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, AW'($urandom), 8'($urandom));
    idle(2);

    // re-arm during drain: no done pulse, checksum restarts
    done_seen = 0;
    tick(1'b1, 1'b1, 22'h000100, 8'h10);
    tick(1'b1, 1'b1, 22'h008100, 8'h20);
    tick(1'b0, 1'b0, '0, 8'd0);
    tick(1'b1, 1'b1, 22'h00C100, 8'h30);
    tick(1'b1, 1'b1, 22'h010100, 8'h40);
    idle(5);
    chk_eq("rearm_done_once", 32'(done_seen), 32'd1);

    // randomised configurations and downloads
    for (int k = 0; k < 8; k++) begin
      rand_cfg();
      idle(2);
      rand_download($urandom_range(20, 60));
    end

    // reset with a byte in flight
    st[0] = 22'h000000; st[1] = 22'h008000; st[2] = 22'h00C000; st[3] = 22'h010000;
    md[0] = 2'd0; md[1] = 2'd1; md[2] = 2'd2; md[3] = 2'd3;
    apply_cfg();
    idle(2);
    tick(1'b1, 1'b0, '0, 8'd0);
    tick(1'b1, 1'b1, 22'h007FFF, 8'hA5);
    ioctl_wr = 1'b0; ioctl_rom = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("rstmid_pre_wr",  32'(pre_wr),   32'd0);
      chk_eq("rstmid_prom_we", 32'(prom_we),  32'd0);
      chk_eq("rstmid_done",    32'(dwn_done), 32'd0);
      chk_eq("rstmid_cksum",   32'(cksum),    32'd0);
    end
    rst_n = 1'b1;
    model_reset();
    tick(1'b0, 1'b1, 22'h008000, 8'h5C);
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
